bus_arbiter_32: RTL

BUS_ARBITER_32 -- requirements
Module: bus_arbiter_32

---
 rtl/bus_arbiter_32_pkg.sv | 22 ++
 rtl/bus_arbiter_32_if.sv | 26 ++
 rtl/bus_arbiter_32_rr_pick32.sv | 38 +++
 rtl/bus_arbiter_32.sv | 131 +++++++++++++
 4 files changed

// File: rtl/bus_arbiter_32_pkg.sv
// Shared constants and types for the 32-source round-robin bus arbiter.
package bus_arbiter_32_pkg;

  localparam int unsigned N_SRC        = 32;
  localparam int unsigned IDX_W        = 5;
  localparam int unsigned HOLD_W       = 8;
  localparam int unsigned MAX_HOLD_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } arb_state_t;

  // One-hot vector with only bit idx set.
  function automatic logic [N_SRC-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
    logic [N_SRC-1:0] one;
    one = {{(N_SRC-1){1'b0}}, 1'b1};
    return one << idx;
  endfunction

endpackage

// File: rtl/bus_arbiter_32_if.sv
// Request/grant bundle between the requesters and the arbiter.
// Handshake: each source raises req[k] and keeps it high for as long as it
// wants the bus; req_mask[k]=0 hides that request. The arbiter answers with a
// registered one-hot gnt (or zero); a source owns the bus only while its gnt
// bit is high, and loses it when it drops req or after MAX_HOLD cycles.
interface bus_arbiter_32_if;
  import bus_arbiter_32_pkg::*;

  logic [N_SRC-1:0] req;
  logic [N_SRC-1:0] req_mask;
  logic [N_SRC-1:0] gnt;
  logic [IDX_W-1:0] gnt_idx;
  logic             bus_busy;
  logic             hold_timeout;

  modport master (
    output req, req_mask,
    input  gnt, gnt_idx, bus_busy, hold_timeout
  );

  modport slave (
    input  req, req_mask,
    output gnt, gnt_idx, bus_busy, hold_timeout
  );

endinterface

// File: rtl/bus_arbiter_32_rr_pick32.sv
// Combinational round-robin winner search: first set bit of eff at or above
// ptr, wrapping from 31 to 0.
module rr_pick32
  import bus_arbiter_32_pkg::*;
(
  input  logic [N_SRC-1:0] i_eff,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N_SRC-1:0] o_gnt,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_any
);

  logic [2*N_SRC-1:0] w_dbl;
  logic [N_SRC-1:0]   w_rot;
  logic [IDX_W-1:0]   w_off;

  // Rotate so that bit 0 of w_rot is the source at ptr.
  assign w_dbl = {i_eff, i_eff} >> i_ptr;
  assign w_rot = w_dbl[N_SRC-1:0];
  assign o_any = |i_eff;

  // Lowest set bit of the rotated vector is the winner's distance from ptr.
  always_comb begin
    w_off = '0;
    for (int k = N_SRC - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_off = IDX_W'(k);
      end
    end
  end

  // Undo the rotation; 5-bit addition wraps modulo 32.
  always_comb begin
    o_idx = i_ptr + w_off;
    o_gnt = o_any ? idx_to_onehot(o_idx) : '0;
  end

endmodule

// File: rtl/bus_arbiter_32.sv
// 32-source round-robin bus arbiter with per-owner hold limit and a one-cycle
// dead GAP between owners. Grant outputs are registered.
module bus_arbiter_32
  import bus_arbiter_32_pkg::*;
#(
  parameter int unsigned MAX_HOLD = MAX_HOLD_DEF
) (
  input  logic                  clock,
  input  logic                  clear_n,
  bus_arbiter_32_if.slave       bus,
  output arb_state_t            o_dbg_state,
  output logic [IDX_W-1:0]      o_dbg_ptr,
  output logic [HOLD_W-1:0]     o_dbg_hold_cnt
);

  arb_state_t        r_state;
  logic [IDX_W-1:0]  r_ptr;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic [N_SRC-1:0]  r_gnt;
  logic [IDX_W-1:0]  r_gnt_idx;
  logic              r_busy;
  logic              r_timeout;

  arb_state_t        w_state_nxt;
  logic [IDX_W-1:0]  w_ptr_nxt;
  logic [HOLD_W-1:0] w_hold_nxt;
  logic [N_SRC-1:0]  w_gnt_nxt;
  logic [IDX_W-1:0]  w_idx_nxt;
  logic              w_busy_nxt;
  logic              w_timeout_nxt;

  logic [N_SRC-1:0]  w_eff;
  logic [N_SRC-1:0]  w_pick_gnt;
  logic [IDX_W-1:0]  w_pick_idx;
  logic              w_pick_any;
  logic              w_owner_req;
  logic              w_hold_done;

  assign w_eff       = bus.req & bus.req_mask;
  // The current owner is r_gnt_idx; a mask clear counts as a plain drop.
  assign w_owner_req = w_eff[r_gnt_idx];
  assign w_hold_done = (r_hold_cnt >= HOLD_W'(MAX_HOLD));

  rr_pick32 u_pick (
    .i_eff (w_eff),
    .i_ptr (r_ptr),
    .o_gnt (w_pick_gnt),
    .o_idx (w_pick_idx),
    .o_any (w_pick_any)
  );

  // State and registered outputs; reset drops the grant at once, no GAP.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      r_state    <= ST_IDLE;
      r_ptr      <= '0;
      r_hold_cnt <= '0;
      r_gnt      <= '0;
      r_gnt_idx  <= '0;
      r_busy     <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_ptr      <= w_ptr_nxt;
      r_hold_cnt <= w_hold_nxt;
      r_gnt      <= w_gnt_nxt;
      r_gnt_idx  <= w_idx_nxt;
      r_busy     <= w_busy_nxt;
      r_timeout  <= w_timeout_nxt;
    end
  end

  // Next state: grant on any effective request, leave on drop or hold limit.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_pick_any) w_state_nxt = ST_GRANT;
      ST_GRANT: if (!w_owner_req || w_hold_done) w_state_nxt = ST_GAP;
      ST_GAP:   w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Next output/datapath values; a drop wins over a simultaneous hold expiry.
  always_comb begin
    w_gnt_nxt     = '0;
    w_idx_nxt     = '0;
    w_busy_nxt    = 1'b0;
    w_timeout_nxt = 1'b0;
    w_ptr_nxt     = r_ptr;
    w_hold_nxt    = r_hold_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_pick_any) begin
          w_gnt_nxt  = w_pick_gnt;
          w_idx_nxt  = w_pick_idx;
          w_busy_nxt = 1'b1;
          w_hold_nxt = HOLD_W'(1);
        end
      end
      ST_GRANT: begin
        if (!w_owner_req) begin
          w_ptr_nxt  = r_gnt_idx + IDX_W'(1);
          w_hold_nxt = '0;
        end else if (w_hold_done) begin
          w_ptr_nxt     = r_gnt_idx + IDX_W'(1);
          w_hold_nxt    = '0;
          w_timeout_nxt = 1'b1;
        end else begin
          w_gnt_nxt  = r_gnt;
          w_idx_nxt  = r_gnt_idx;
          w_busy_nxt = 1'b1;
          w_hold_nxt = r_hold_cnt + HOLD_W'(1);
        end
      end
      default: begin
        w_hold_nxt = '0;
      end
    endcase
  end

  assign bus.gnt          = r_gnt;
  assign bus.gnt_idx      = r_gnt_idx;
  assign bus.bus_busy     = r_busy;
  assign bus.hold_timeout = r_timeout;

  assign o_dbg_state    = r_state;
  assign o_dbg_ptr      = r_ptr;
  assign o_dbg_hold_cnt = r_hold_cnt;

endmodule
